data_mem_arbiter: RTL and testbench

//  Shares the single data_mem port between the core load/store unit and a DMA requester.
//  Two-way round-robin arbitration; optional DMA bus lock with bounded hold.
//  Out-of-range addresses are filtered so they never reach data_mem.

---
 rtl/data_mem_arbiter_pkg.sv | 32 +++
 rtl/data_mem_arbiter_if.sv | 23 ++
 rtl/data_mem_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/data_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data_mem arbiter: segment defaults, size and
// state encodings, requester ids and the address range helper.
package data_mem_arbiter_pkg;

  localparam logic [63:0] DATA_START_DEF = 64'h0000_0000_1000_0000;
  localparam logic [63:0] DATA_BYTES_DEF = 64'h0000_0000_0000_8000;
  localparam int          LOCK_MAX_DEF   = 16;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_t;

  // The upper bound is formed in 65 bits so a segment ending at the top of
  // the address space never wraps around to a small limit.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] bytes);
    logic [64:0] limit;
    limit = {1'b0, base} + {1'b0, bytes};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester's view of the shared data_mem port: request fields going in,
// grant and one-cycle response coming back.
interface data_mem_arbiter_if;
  logic        req;
  logic        we;
  logic        size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (
    output req, we, size, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic. Bit 0 is the core, bit 1 is the DMA.
// While lock_owner is high only the DMA can be granted.
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock_owner,
  input  logic       en,
  output logic [1:0] gnt,
  output req_id_t    last_grant
);

  // Combinational grant: lock first, then alternate on contention.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (lock_owner) begin
        gnt[1] = req[1];
      end else if (req == 2'b11) begin
        gnt = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the most recent winner; reset favours the core on first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_DMA;
    end else if (gnt[0]) begin
      last_grant <= REQ_CORE;
    end else if (gnt[1]) begin
      last_grant <= REQ_DMA;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data_mem port between the core load/store unit and a DMA
// requester. Round-robin arbitration, a bounded DMA bus lock, and filtering of
// addresses outside the data segment.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_RR     | round-robin between core and DMA
//   ST_LOCKED | DMA owns the port; released by dma_lock=0 or count expiry
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter logic [63:0] DATA_START = DATA_START_DEF,
  parameter logic [63:0] DATA_BYTES = DATA_BYTES_DEF,
  parameter int          LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_arbiter_if.slave  core,
  data_mem_arbiter_if.slave  dma,
  input  logic               dma_lock,
  output logic [63:0]        mem_addr,
  output logic [63:0]        mem_data_in,
  output logic               mem_word_we,
  output logic               mem_byte_we,
  input  logic [63:0]        mem_data_out
);

  localparam int              CW        = $clog2(LOCK_MAX);
  localparam logic [CW-1:0]   LOCK_LAST = CW'(LOCK_MAX - 1);

  lock_state_t   state;
  logic [CW-1:0] lock_left;
  logic [1:0]    gnt;
  req_id_t       last_grant;

  logic          core_acc;
  logic          dma_acc;
  logic          sel_we;
  logic          sel_size;
  logic          in_range;

  logic          core_rvalid_q;
  logic          core_err_q;
  logic [63:0]   core_rdata_q;
  logic          dma_rvalid_q;
  logic          dma_err_q;
  logic [63:0]   dma_rdata_q;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({dma.req, core.req}),
    .lock_owner (state == ST_LOCKED),
    .en         (~reset),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  assign core_acc = gnt[0];
  assign dma_acc  = gnt[1];
  assign core.gnt = gnt[0];
  assign dma.gnt  = gnt[1];

  // Route the winner onto the memory port; nothing granted drives all zeros.
  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    sel_we      = 1'b0;
    sel_size    = SIZE_BYTE;
    if (core_acc) begin
      mem_addr    = core.addr;
      mem_data_in = core.wdata;
      sel_we      = core.we;
      sel_size    = core.size;
    end else if (dma_acc) begin
      mem_addr    = dma.addr;
      mem_data_in = dma.wdata;
      sel_we      = dma.we;
      sel_size    = dma.size;
    end
    in_range    = addr_in_range(mem_addr, DATA_START, DATA_BYTES);
    mem_word_we = (core_acc | dma_acc) & sel_we & (sel_size == SIZE_WORD) & in_range;
    mem_byte_we = (core_acc | dma_acc) & sel_we & (sel_size == SIZE_BYTE) & in_range;
  end

  // Lock FSM; lock_left counts down the cycles DMA may still hold the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RR;
      lock_left <= '0;
    end else if (state == ST_RR) begin
      if (dma_acc && dma_lock) begin
        state     <= ST_LOCKED;
        lock_left <= LOCK_LAST;
      end
    end else begin
      if (lock_left == '0) begin
        state <= ST_RR;
      end else if (dma_acc && !dma_lock) begin
        state <= ST_RR;
      end else begin
        lock_left <= lock_left - CW'(1);
      end
    end
  end

  // One-cycle response for whichever side was accepted this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_rvalid_q <= 1'b0;
      core_err_q    <= 1'b0;
      core_rdata_q  <= '0;
      dma_rvalid_q  <= 1'b0;
      dma_err_q     <= 1'b0;
      dma_rdata_q   <= '0;
    end else begin
      core_rvalid_q <= core_acc;
      core_err_q    <= core_acc & ~in_range;
      core_rdata_q  <= (core_acc & ~sel_we & in_range) ? mem_data_out : '0;
      dma_rvalid_q  <= dma_acc;
      dma_err_q     <= dma_acc & ~in_range;
      dma_rdata_q   <= (dma_acc & ~sel_we & in_range) ? mem_data_out : '0;
    end
  end

  assign core.rvalid = core_rvalid_q;
  assign core.err    = core_err_q;
  assign core.rdata  = core_rdata_q;
  assign dma.rvalid  = dma_rvalid_q;
  assign dma.err     = dma_err_q;
  assign dma.rdata   = dma_rdata_q;

  // A lock is only ever entered on a DMA acceptance, so its owner is the DMA.
  a_lock_owner: assert property (@(posedge clk) disable iff (reset)
    (state == ST_LOCKED) |-> (last_grant == REQ_DMA));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small data_mem model.
module tb_data_mem_arbiter;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] A8 = 64'h0000_0000_1000_0008;
  localparam logic [63:0] AX = 64'h0000_0000_1000_0010;
  localparam logic [63:0] W  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] P2 = 64'hA5A5_0000_0000_0002;
  localparam logic [63:0] PB = 64'hA5A5_0000_AB00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_lock;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_in;
  logic        mem_word_we;
  logic        mem_byte_we;
  logic [63:0] mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_arbiter_if core_if();
  data_mem_arbiter_if dma_if();

  data_mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .core         (core_if),
    .dma          (dma_if),
    .dma_lock     (dma_lock),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_word_we  (mem_word_we),
    .mem_byte_we  (mem_byte_we),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // data_mem model: 4096 words indexed by addr[14:3], written on negedge.
  logic [63:0] mem [4096];
  assign mem_data_out = mem[mem_addr[14:3]];
  always @(negedge clk) begin
    if (mem_word_we) mem[mem_addr[14:3]] <= mem_data_in;
    else if (mem_byte_we) mem[mem_addr[14:3]][{mem_addr[2:0], 3'b000} +: 8] <= mem_data_in[7:0];
  end

  typedef struct {
    logic c_req, c_we, c_size; logic [63:0] c_addr, c_wdata;
    logic d_req, d_we, d_size; logic [63:0] d_addr, d_wdata; logic d_lock;
    logic e_cgnt, e_dgnt, e_wwe, e_bwe; logic [63:0] e_maddr;
    logic e_crv, e_cerr; logic [63:0] e_crd;
    logic e_drv, e_derr; logic [63:0] e_drd;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic cs, input logic [63:0] ca, input logic [63:0] cd,
                       input logic dr, input logic dw, input logic ds, input logic [63:0] da, input logic [63:0] dd,
                       input logic dl);
    core_if.req = cr; core_if.we = cw; core_if.size = cs; core_if.addr = ca; core_if.wdata = cd;
    dma_if.req  = dr; dma_if.we  = dw; dma_if.size  = ds; dma_if.addr  = da; dma_if.wdata  = dd;
    dma_lock = dl;
  endtask

  initial begin
    int starve;
    for (int i = 0; i < 4096; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);

    //          c_req c_we c_sz c_addr c_wdata        d_req d_we d_sz d_addr d_wdata d_lock  cgnt dgnt wwe bwe maddr  crv cerr crd  drv derr drd
    vecs[0]  = '{H, H, H, A8, W,                       L, L, L, Z, Z, L,  H, L, H, L, A8,  L, L, Z,  L, L, Z};
    vecs[1]  = '{H, L, H, A8, Z,                       L, L, L, Z, Z, L,  H, L, L, L, A8,  H, L, Z,  L, L, Z};
    vecs[2]  = '{L, L, L, Z, Z,                        L, L, L, Z, Z, L,  L, L, L, L, Z,   H, L, W,  L, L, Z};
    vecs[3]  = '{L, L, L, Z, Z,                        H, L, H, A8, Z, L, L, H, L, L, A8,  L, L, Z,  L, L, Z};
    vecs[4]  = '{H, L, H, A8, Z,                       H, L, H, AX, Z, L, H, L, L, L, A8,  L, L, Z,  H, L, W};
    vecs[5]  = '{H, L, H, A8, Z,                       H, L, H, AX, Z, L, L, H, L, L, AX,  H, L, W,  L, L, Z};
    vecs[6]  = '{H, L, H, A8, Z,                       H, L, H, AX, Z, L, H, L, L, L, A8,  L, L, Z,  H, L, P2};
    vecs[7]  = '{H, L, H, A8, Z,                       H, L, H, AX, Z, L, L, H, L, L, AX,  H, L, W,  L, L, Z};
    vecs[8]  = '{H, L, H, A8, Z,                       H, L, H, AX, Z, L, H, L, L, L, A8,  L, L, Z,  H, L, P2};
    vecs[9]  = '{H, L, H, A8, Z,                       H, L, H, AX, Z, L, L, H, L, L, AX,  H, L, W,  L, L, Z};
    vecs[10] = '{L, L, L, Z, Z,                        L, L, L, Z, Z, L,  L, L, L, L, Z,   L, L, Z,  H, L, P2};
    vecs[11] = '{H, H, L, 64'h10000003, 64'hFFFFFFFFFFFFFFAB, L, L, L, Z, Z, L, H, L, L, H, 64'h10000003, L, L, Z, L, L, Z};
    vecs[12] = '{H, L, H, 64'h10000000, Z,             L, L, L, Z, Z, L,  H, L, L, L, 64'h10000000, H, L, Z, L, L, Z};
    vecs[13] = '{L, L, L, Z, Z,                        L, L, L, Z, Z, L,  L, L, L, L, Z,   H, L, PB, L, L, Z};
    vecs[14] = '{H, L, H, 64'h0FFFFFF8, Z,             H, H, H, 64'h10008000, 64'hDEADBEEF00000000, L, L, H, L, L, 64'h10008000, L, L, Z, L, L, Z};
    vecs[15] = '{H, L, H, 64'h0FFFFFF8, Z,             L, L, L, Z, Z, L,  H, L, L, L, 64'h0FFFFFF8, L, L, Z, H, H, Z};
    vecs[16] = '{H, L, H, 64'h10000000, Z,             L, L, L, Z, Z, L,  H, L, L, L, 64'h10000000, H, H, Z, L, L, Z};
    vecs[17] = '{L, L, L, Z, Z,                        L, L, L, Z, Z, L,  L, L, L, L, Z,   H, L, PB, L, L, Z};
    vecs[18] = '{L, L, L, Z, Z,                        H, L, H, 64'h10007FF8, Z, L, L, H, L, L, 64'h10007FF8, L, L, Z, L, L, Z};
    vecs[19] = '{L, L, L, Z, Z,                        L, L, L, Z, Z, L,  L, L, L, L, Z,   L, L, Z,  H, L, 64'hA5A5000000000FFF};

    // Reset with both sides requesting writes: nothing may be granted.
    reset = 1'b1;
    drive(H, H, H, A8, W, H, H, H, AX, W, L);
    next_cycle();
    next_cycle();
    #2;
    chk("rst core_gnt", 64'(core_if.gnt), Z);
    chk("rst dma_gnt", 64'(dma_if.gnt), Z);
    chk("rst word_we", 64'(mem_word_we), Z);
    chk("rst mem_addr", mem_addr, Z);
    chk("rst core_rvalid", 64'(core_if.rvalid), Z);
    chk("rst dma_rvalid", 64'(dma_if.rvalid), Z);
    chk("rst core_rdata", core_if.rdata, Z);
    chk("rst core_err", 64'(core_if.err), Z);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_size, vecs[i].c_addr, vecs[i].c_wdata,
            vecs[i].d_req, vecs[i].d_we, vecs[i].d_size, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].d_lock);
      #2;
      chk($sformatf("v%0d core_gnt", i), 64'(core_if.gnt), 64'(vecs[i].e_cgnt));
      chk($sformatf("v%0d dma_gnt", i), 64'(dma_if.gnt), 64'(vecs[i].e_dgnt));
      chk($sformatf("v%0d word_we", i), 64'(mem_word_we), 64'(vecs[i].e_wwe));
      chk($sformatf("v%0d byte_we", i), 64'(mem_byte_we), 64'(vecs[i].e_bwe));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d core_rvalid", i), 64'(core_if.rvalid), 64'(vecs[i].e_crv));
      chk($sformatf("v%0d core_err", i), 64'(core_if.err), 64'(vecs[i].e_cerr));
      chk($sformatf("v%0d core_rdata", i), core_if.rdata, vecs[i].e_crd);
      chk($sformatf("v%0d dma_rvalid", i), 64'(dma_if.rvalid), 64'(vecs[i].e_drv));
      chk($sformatf("v%0d dma_err", i), 64'(dma_if.err), 64'(vecs[i].e_derr));
      chk($sformatf("v%0d dma_rdata", i), dma_if.rdata, vecs[i].e_drd);
      next_cycle();
    end

    // Forced release: idle DMA holds the lock for LOCK_MAX cycles.
    drive(H, L, H, 64'h10000000, Z, L, L, L, Z, Z, L);
    #2; chk("lockA pre core_gnt", 64'(core_if.gnt), 64'(H));
    next_cycle();
    drive(H, L, H, 64'h10000000, Z, H, L, H, A8, Z, H);
    #2; chk("lockA acc dma_gnt", 64'(dma_if.gnt), 64'(H));
    chk("lockA acc core_gnt", 64'(core_if.gnt), 64'(L));
    next_cycle();
    drive(H, L, H, 64'h10000000, Z, L, L, L, Z, Z, L);
    starve = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (core_if.gnt) break;
      starve++;
      next_cycle();
    end
    chk("lockA starve cycles", 64'(starve), 64'd4);
    chk("lockA release core_gnt", 64'(core_if.gnt), 64'(H));
    next_cycle();

    // Early release: dma_lock=0 acceptance returns to round-robin at once.
    drive(H, L, H, 64'h10000000, Z, H, L, H, A8, Z, H);
    #2; chk("lockB acc dma_gnt", 64'(dma_if.gnt), 64'(H));
    next_cycle();
    drive(H, L, H, 64'h10000000, Z, H, L, H, A8, Z, L);
    #2; chk("lockB unlock dma_gnt", 64'(dma_if.gnt), 64'(H));
    chk("lockB unlock core_gnt", 64'(core_if.gnt), 64'(L));
    next_cycle();
    #2; chk("lockB after core_gnt", 64'(core_if.gnt), 64'(H));
    chk("lockB after dma_gnt", 64'(dma_if.gnt), 64'(L));
    next_cycle();

    // DMA keeps asking for the lock; the forced release still hands over to the core.
    drive(H, L, H, 64'h10000000, Z, H, L, H, A8, Z, H);
    #2; chk("lockC acc dma_gnt", 64'(dma_if.gnt), 64'(H));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("lockC c%0d dma_gnt", k), 64'(dma_if.gnt), 64'(H));
      chk($sformatf("lockC c%0d core_gnt", k), 64'(core_if.gnt), 64'(L));
      next_cycle();
    end
    #2; chk("lockC end core_gnt", 64'(core_if.gnt), 64'(H));
    chk("lockC end dma_gnt", 64'(dma_if.gnt), 64'(L));
    chk("lockC end dma_rvalid", 64'(dma_if.rvalid), 64'(H));
    next_cycle();

    // Reset for one cycle in the middle of traffic.
    drive(H, H, H, 64'h10000018, 64'h0BADF00D, L, L, L, Z, Z, L);
    #2; chk("rst6 pre core_gnt", 64'(core_if.gnt), 64'(H));
    next_cycle();
    reset = 1'b1;
    drive(H, H, H, 64'h10000018, 64'h0BADF00D, H, L, H, A8, Z, L);
    #2; chk("rst6 core_gnt", 64'(core_if.gnt), 64'(L));
    chk("rst6 dma_gnt", 64'(dma_if.gnt), 64'(L));
    chk("rst6 word_we", 64'(mem_word_we), 64'(L));
    chk("rst6 mem_addr", mem_addr, Z);
    next_cycle();
    reset = 1'b0;
    #2; chk("rst6 post core_rvalid", 64'(core_if.rvalid), 64'(L));
    chk("rst6 post dma_rvalid", 64'(dma_if.rvalid), 64'(L));
    chk("rst6 post core_gnt", 64'(core_if.gnt), 64'(H));
    chk("rst6 post dma_gnt", 64'(dma_if.gnt), 64'(L));
    next_cycle();
    drive(L, L, L, Z, Z, L, L, L, Z, Z, L);
    #2; chk("rst6 resp core_rvalid", 64'(core_if.rvalid), 64'(H));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
